// File: rtl/alu_pkg.sv
// Shared types for alu_exec_unit: opcodes, FSM states, datapath width and
// the single-cycle reference evaluation used by both shift builds.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1001;
  localparam logic [3:0] OP_SLT = 4'b1011;
  localparam logic [3:0] OP_JAL = 4'b1110;
  localparam logic [3:0] OP_BGE = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              cond;
    logic              illegal;
  } alu_res_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic alu_res_t alu_eval(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [3:0]        op);
    alu_res_t r;
    r = '0;
    case (op)
      OP_AND: r.result = a & b;
      OP_XOR: r.result = a ^ b;
      OP_ADD: r.result = a + b;
      OP_SLL: r.result = a << b[4:0];
      OP_SRL: r.result = a >> b[4:0];
      OP_SRA: r.result = $unsigned($signed(a) >>> b[4:0]);
      OP_EQ:  r.cond   = (a == b);
      OP_NE: begin
        r.result = a | b;
        r.cond   = (a != b);
      end
      OP_SLT: begin
        r.cond   = ($signed(a) < $signed(b));
        r.result = {{(DATA_W-1){1'b0}}, r.cond};
      end
      OP_BGE: begin
        r.cond   = ($signed(a) >= $signed(b));
        r.result = {{(DATA_W-1){1'b0}}, r.cond};
      end
      OP_JAL: begin
        r.result = a + 32'd4;
        r.cond   = 1'b1;
      end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// One-bit-per-cycle shifter: loads on i_start, shifts i_amt times, then raises o_done.
// Latency i_amt cycles after the load; no backpressure, the owner samples o_done.
module alu_shift_serial
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic [4:0]        i_amt,
  input  logic              i_right,
  input  logic              i_arith,
  output logic [DATA_W-1:0] o_data,
  output logic              o_done
);

  logic [DATA_W-1:0] r_data;
  logic [4:0]        r_cnt;
  logic              r_done;
  logic              r_right;
  logic              r_arith;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_right <= 1'b0;
      r_arith <= 1'b0;
    end else if (i_start) begin
      r_data  <= i_data;
      r_cnt   <= i_amt;
      r_done  <= (i_amt == 5'd0);
      r_right <= i_right;
      r_arith <= i_arith;
    end else if (r_cnt != 5'd0) begin
      r_data <= r_right ? {r_arith & r_data[DATA_W-1], r_data[DATA_W-1:1]}
                        : {r_data[DATA_W-2:0], 1'b0};
      r_cnt  <= r_cnt - 5'd1;
      r_done <= (r_cnt == 5'd1);
    end
  end

  assign o_data = r_data;
  assign o_done = r_done;

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU: one request in flight, result held in DONE until OutReady (1 cycle, shifts N+1 serial).
// Define FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shift.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [3:0]        Operation,
  input  logic              InValid,
  output logic              InReady,
  output logic [DATA_W-1:0] Result,
  output logic              Cond,
  output logic              Illegal,
  output logic              OutValid,
  input  logic              OutReady
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_result;
  logic              r_cond;
  logic              r_illegal;
  alu_res_t          w_eval;
  logic              w_accept;
  logic              w_serial;
  logic              w_sh_done;
  logic [DATA_W-1:0] w_sh_data;

  assign w_accept = InValid && (r_state == ST_IDLE);
  assign w_eval   = alu_eval(SrcA, SrcB, Operation);

`ifdef FAST_SHIFT_EN
  assign w_serial  = 1'b0;
  assign w_sh_done = 1'b0;
  assign w_sh_data = '0;
`else
  // Zero-amount shifts bypass the serial path; the barrel result equals A.
  assign w_serial = is_shift(Operation) && (SrcB[4:0] != 5'd0);

  alu_shift_serial u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_serial),
    .i_data  (SrcA),
    .i_amt   (SrcB[4:0]),
    .i_right (Operation[0]),
    .i_arith (Operation[1]),
    .o_data  (w_sh_data),
    .o_done  (w_sh_done)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_serial ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (w_sh_done) w_state_nxt = ST_DONE;
      ST_DONE:  if (OutReady) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_cond    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_serial) begin
      r_result  <= w_eval.result;
      r_cond    <= w_eval.cond;
      r_illegal <= w_eval.illegal;
    end else if ((r_state == ST_SHIFT) && w_sh_done) begin
      r_result  <= w_sh_data;
      r_cond    <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  assign InReady  = (r_state == ST_IDLE);
  assign OutValid = (r_state == ST_DONE);
  assign Result   = r_result;
  assign Cond     = r_cond;
  assign Illegal  = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, corner sequences and random ops vs. an arithmetic model.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [3:0]  Operation = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] Result;
  logic        Cond;
  logic        Illegal;
  logic        OutValid;
  logic        OutReady = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .InValid(InValid), .InReady(InReady), .Result(Result), .Cond(Cond),
    .Illegal(Illegal), .OutValid(OutValid), .OutReady(OutReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Model from arithmetic definitions: shifts as multiply / floor-divide by 2^n.
  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output logic [31:0] r, output logic c, output logic il);
    longint sa, sb, p, q;
    logic [63:0] ua, prod;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    n  = int'(b % 32);
    p  = longint'(1) << n;
    r = '0; c = 1'b0; il = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a ^ b;
      4'b0010: r = 32'((ua + {32'd0, b}) % 64'h1_0000_0000);
      4'b0100: begin prod = ua * 64'(p); r = prod[31:0]; end
      4'b0101: r = 32'(ua / 64'(p));
      4'b0111: begin
        q = (sa < 0) ? -((-sa + p - 1) / p) : sa / p;
        r = 32'(q);
      end
      4'b1000: c = (a == b);
      4'b1001: begin r = a | b; c = (a != b); end
      4'b1011: begin c = (sa < sb); r = {31'd0, c}; end
      4'b1111: begin c = (sa >= sb); r = {31'd0, c}; end
      4'b1110: begin r = 32'(ua + 64'd4); c = 1'b1; end
      default: il = 1'b1;
    endcase
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
    int amt;
    amt = int'(b % 32);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && amt != 0) return amt + 1;
    return 1;
`endif
  endfunction

  // Issue one request, wait for OutValid, hold for 'hold' cycles, then consume.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input int hold, output logic [31:0] res, output logic c,
                       output logic il, output int lat, output logic ir_low);
    int guard;
    guard = 0;
    while (!InReady && guard < 50) begin @(posedge clk); #1; guard++; end
    SrcA = a; SrcB = b; Operation = op; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    lat = 0;
    ir_low = !InReady;
    do begin
      @(posedge clk); #1;
      lat++;
      if (InReady) ir_low = 1'b0;
    end while (!OutValid && lat < 100);
    repeat (hold) begin @(posedge clk); #1; end
    res = Result; c = Cond; il = Illegal;
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        c;
    logic        il;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] r, er;
    logic c, il, ec, eil, irl, ov_seen;
    int lat;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h1,         4'b0010, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 32'h00F0_1234, 1'b0, 1'b0};
    vecs[2]  = '{32'hAAAA_5555, 32'hFFFF_0000, 4'b0001, 32'h5555_5555, 1'b0, 1'b0};
    vecs[3]  = '{32'h1200_0034, 32'h0000_5600, 4'b1001, 32'h1200_5634, 1'b1, 1'b0};
    vecs[4]  = '{32'h5,         32'h5,         4'b1001, 32'h5,         1'b0, 1'b0};
    vecs[5]  = '{32'h7,         32'h7,         4'b1000, 32'h0,         1'b1, 1'b0};
    vecs[6]  = '{32'h7,         32'h8,         4'b1000, 32'h0,         1'b0, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0,         4'b1011, 32'h1,         1'b1, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFF, 32'h0,         4'b1111, 32'h0,         1'b0, 1'b0};
    vecs[9]  = '{32'h5,         32'h5,         4'b1111, 32'h1,         1'b1, 1'b0};
    vecs[10] = '{32'h0000_1000, 32'h1234,      4'b1110, 32'h0000_1004, 1'b1, 1'b0};
    vecs[11] = '{32'h1234_5678, 32'h9,         4'b0011, 32'h0,         1'b0, 1'b1};
    vecs[12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, 32'h0,         1'b0, 1'b1};
    vecs[13] = '{32'h0000_0001, 32'h0,         4'b0100, 32'h1,         1'b0, 1'b0};
    vecs[14] = '{32'h8000_0000, 32'd31,        4'b0101, 32'h1,         1'b0, 1'b0};
    vecs[15] = '{32'h8000_0000, 32'd4,         4'b0111, 32'hF800_0000, 1'b0, 1'b0};
    vecs[16] = '{32'h0000_0001, 32'h25,        4'b0100, 32'h20,        1'b0, 1'b0};

    #12;
    check("reset OutValid", OutValid, 0);
    check("reset Result", Result, 0);
    check("reset Cond", Cond, 0);
    check("reset Illegal", Illegal, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("InReady after reset", InReady, 1);

    for (int i = 0; i < 17; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, r, c, il, lat, irl);
      check($sformatf("vec%0d result", i), r, vecs[i].res);
      check($sformatf("vec%0d cond", i), c, vecs[i].c);
      check($sformatf("vec%0d illegal", i), il, vecs[i].il);
      check($sformatf("vec%0d latency", i), lat, exp_lat(vecs[i].op, vecs[i].b));
      check($sformatf("vec%0d InReady low while busy", i), irl, 1);
    end

    // Backpressure: response held while OutReady is low, new requests ignored.
    SrcA = 32'd3; SrcB = 32'd4; Operation = 4'b0010; InValid = 1'b1;
    @(posedge clk); #1;
    SrcA = 32'd100; SrcB = 32'd200;
    check("bp OutValid", OutValid, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d result", k), Result, 32'd7);
      check($sformatf("bp hold%0d OutValid", k), OutValid, 1);
      check($sformatf("bp hold%0d InReady", k), InReady, 0);
    end
    InValid = 1'b0; OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    check("bp back to idle InReady", InReady, 1);
    check("bp back to idle OutValid", OutValid, 0);
    ov_seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; ov_seen |= OutValid; end
    check("bp ignored request not queued", ov_seen, 0);

    // OutReady while idle must not disturb anything.
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    check("OutReady idle no effect", InReady, 1);

    // Reset in the middle of a long shift.
    SrcA = 32'h1; SrcB = 32'd31; Operation = 4'b0100; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset OutValid", OutValid, 0);
    check("midreset Result", Result, 0);
    check("midreset Cond", Cond, 0);
    check("midreset Illegal", Illegal, 0);
    check("midreset InReady", InReady, 1);
    @(negedge clk); rst_n = 1'b1;
    ov_seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; ov_seen |= OutValid; end
    check("no response after midreset", ov_seen, 0);
    do_op(32'd10, 32'd20, 4'b0010, 1, r, c, il, lat, irl);
    check("post-reset add result", r, 32'd30);
    check("post-reset add latency", lat, 1);

    // Random operations against the model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      logic [3:0] rop;
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 1) == 0) rb = rb % 8;
      rop = 4'($urandom_range(0, 15));
      ref_alu(ra, rb, rop, er, ec, eil);
      do_op(ra, rb, rop, int'($urandom_range(0, 2)), r, c, il, lat, irl);
      check($sformatf("rnd%0d op%0h result", i, rop), r, er);
      check($sformatf("rnd%0d op%0h cond", i, rop), c, ec);
      check($sformatf("rnd%0d op%0h illegal", i, rop), il, eil);
      check($sformatf("rnd%0d op%0h latency", i, rop), lat, exp_lat(rop, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The module SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Ports SHALL be: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-003 Ports SHALL be: SrcA  in  32  operand A; SrcB  in  32  operand B; Operation  in  4  ALU operation code.
REQ-004 Ports SHALL be: InValid  in  1  request valid; InReady  out  1  unit can accept a request.
REQ-005 Ports SHALL be: Result  out  32  result; Cond  out  1  branch condition; Illegal  out  1  unsupported code.
REQ-006 Ports SHALL be: OutValid  out  1  response valid; OutReady  in  1  consumer accepts the response.

Function
REQ-007 Opcodes SHALL be: 0000 AND, 0001 XOR, 0010 ADD, 0100 SLL, 0101 SRL, 0111 SRA, 1000 EQ, 1001 OR/NE, 1011 SLT/BLT, 1110 JAL, 1111 BGE.
REQ-008 AND, XOR and ADD SHALL return A&B, A^B and A+B mod 2^32, with Cond=0.
REQ-009 OR/NE SHALL return Result=A|B and Cond=(A!=B).
REQ-010 EQ SHALL return Result=0 and Cond=(A==B).
REQ-011 SLT/BLT SHALL use a signed comparison, with Cond=(A<B) and Result={31'b0,Cond}.
REQ-012 BGE SHALL use a signed comparison, with Cond=(A>=B) and Result={31'b0,Cond}.
REQ-013 JAL SHALL return Result=A+4 and Cond=1.
REQ-014 Shift amount SHALL be SrcB[4:0]; SRA SHALL replicate A[31].
REQ-015 Any other code SHALL return Result=0, Cond=0 and Illegal=1; Illegal SHALL be 0 for legal codes.
REQ-016 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-017 InReady SHALL be 1 only in IDLE.
REQ-018 A transfer occurs when InValid&InReady; operands and opcode SHALL be captured on that edge.
REQ-019 Non-shift ops, and shifts with amount 0, SHALL go IDLE->DONE, giving OutValid in the cycle after the accept.
REQ-020 Shifts with amount N>0 SHALL go IDLE->SHIFT and move one bit per cycle for N cycles, then ->DONE; OutValid SHALL assert N+1 cycles after the accept.
REQ-021 In DONE, OutValid=1 and Result/Cond/Illegal SHALL hold stable until OutReady=1.
REQ-022 DONE with OutReady=1 SHALL go ->IDLE; the next accept SHALL be possible in the following cycle.
REQ-023 InValid in the SHIFT or DONE state SHALL be ignored, with no capture.
REQ-024 OutReady outside DONE SHALL have no effect.

Reset
REQ-025 When rst_n=0, the state SHALL become IDLE immediately and Result, Cond, Illegal and OutValid SHALL be 0.
REQ-026 Reset mid-SHIFT SHALL discard the operation; no response SHALL be produced.
REQ-027 After rst_n deasserts, InReady SHALL be 1 from the first clk edge.

Configuration
REQ-028 With FAST_SHIFT_EN defined, shifts SHALL use a single-cycle barrel shifter and follow REQ-019; the SHIFT state SHALL be unused.
REQ-029 Without FAST_SHIFT_EN, shifts SHALL follow REQ-020.
REQ-030 Results SHALL be identical in both builds; only latency SHALL differ.

Structure
REQ-031 Package alu_pkg SHALL hold the 4-bit opcode localparams, the FSM state enum and the data width constant (32).
REQ-032 The serial shift datapath (shift register, 5-bit down-counter, done flag) SHALL be the sub-module alu_shift_serial, instantiated only without FAST_SHIFT_EN.

Verification
REQ-033 ADD: A=0xFFFFFFFF, B=1, accept -> next cycle OutValid=1, Result=0, Cond=0, Illegal=0.
REQ-034 SRA: A=0x80000000, B=4, no FAST_SHIFT_EN -> OutValid 5 cycles after accept, Result=0xF8000000, InReady=0 throughout.
REQ-035 BGE: A=-1, B=0 -> Cond=0. BLT: A=-1, B=0 -> Cond=1, Result=1.
REQ-036 Backpressure: OutReady=0 for 3 cycles after OutValid -> Result stable, InReady=0, second InValid ignored. OutReady=1 -> IDLE next cycle.
REQ-037 Opcode 0011 -> Illegal=1, Result=0, latency 1.
REQ-038 SLL by 31 interrupted by rst_n=0 at cycle 10 -> outputs 0 immediately, no OutValid after release, and the next request completes normally.
